// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling stages: default sizes, counter widths
// and the sign-aware maximum used by every pooling lane.
package cnn_pkg;

  localparam int DATAWIDTH = 32;
  localparam int MAX_DW    = 64;
  localparam int IMG_W_DEF = 8;
  localparam int IMG_H_DEF = 8;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W = cnt_w(IMG_W_DEF);
  localparam int ROW_W = cnt_w(IMG_H_DEF);
  localparam int PIX_W = cnt_w(IMG_W_DEF * IMG_H_DEF);

  // Operands arrive already sign- or zero-extended to MAX_DW by the caller.
  function automatic logic [MAX_DW-1:0] max2(input logic [MAX_DW-1:0] a,
                                              input logic [MAX_DW-1:0] b,
                                              input logic              signed_mode);
    logic a_gt;
    if (signed_mode) begin
      a_gt = ($signed(a) > $signed(b));
    end else begin
      a_gt = (a > b);
    end
    return a_gt ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2x2_lane.sv
// One channel of the 2x2/stride-2 max pool: pair register, half-width line
// buffer holding the even-row horizontal maxima, and the output register.
module maxpool2x2_lane
  import cnn_pkg::*;
#(
  parameter int DW     = 32,
  parameter int PW     = 4,
  parameter int IDX_W  = 2,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pair_we,
  input  logic             lb_we,
  input  logic             out_we,
  input  logic [IDX_W-1:0] idx,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout
);

  localparam logic SIGNED_B = (SIGNED != 0);

  logic [DW-1:0]     pair_q, pair_d;
  logic [DW-1:0]     out_q, out_d;
  logic [DW-1:0]     hmax_s;
  logic [DW-1:0]     linebuf_q [PW];
  logic [MAX_DW-1:0] pair_ext_s, din_ext_s, lb_ext_s, hmax_ext_s, vmax_ext_s;

  // Horizontal max of the pair, then vertical max against the buffered row.
  always_comb begin
    pair_ext_s           = {MAX_DW{SIGNED_B & pair_q[DW-1]}};
    pair_ext_s[DW-1:0]   = pair_q;
    din_ext_s            = {MAX_DW{SIGNED_B & din[DW-1]}};
    din_ext_s[DW-1:0]    = din;
    hmax_ext_s           = max2(pair_ext_s, din_ext_s, SIGNED_B);
    hmax_s               = hmax_ext_s[DW-1:0];
    lb_ext_s             = {MAX_DW{SIGNED_B & linebuf_q[idx][DW-1]}};
    lb_ext_s[DW-1:0]     = linebuf_q[idx];
    vmax_ext_s           = max2(lb_ext_s, hmax_ext_s, SIGNED_B);
    pair_d               = pair_q;
    out_d                = out_q;
    if (pair_we) begin
      pair_d = din;
    end else begin
      pair_d = pair_q;
    end
    if (out_we) begin
      out_d = vmax_ext_s[DW-1:0];
    end else begin
      out_d = out_q;
    end
  end

  // Pair and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_q <= '0;
      out_q  <= '0;
    end else begin
      pair_q <= pair_d;
      out_q  <= out_d;
    end
  end

  // Line buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[idx] <= hmax_s;
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/layer2_maxpool2x2_stride2_depth4.sv
// Four-channel 2x2 stride-2 max pool over a raster-order stream; the shared
// col/row counters steer four identical lanes.
module layer2_maxpool2x2_stride2_depth4
  import cnn_pkg::*;
#(
  parameter int IMG_Width  = 8,
  parameter int IMG_Height = 8,
  parameter int Datawidth  = DATAWIDTH,
  parameter int Signed     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [Datawidth-1:0] In_0,
  input  logic [Datawidth-1:0] In_1,
  input  logic [Datawidth-1:0] In_2,
  input  logic [Datawidth-1:0] In_3,
  output logic                 valid_out,
  output logic [Datawidth-1:0] Out_0,
  output logic [Datawidth-1:0] Out_1,
  output logic [Datawidth-1:0] Out_2,
  output logic [Datawidth-1:0] Out_3,
  output logic                 last_out
);

  localparam int PW     = IMG_Width / 2;
  localparam int PH     = IMG_Height / 2;
  localparam int CW     = cnt_w(IMG_Width);
  localparam int RW     = cnt_w(IMG_Height);
  localparam int IDX_W  = cnt_w(PW);

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 valid_out_q, valid_out_d;
  logic                 last_out_q, last_out_d;
  logic                 pair_we_s, lb_we_s, out_we_s;
  logic [IDX_W-1:0]     idx_s;
  logic [Datawidth-1:0] in_s  [4];
  logic [Datawidth-1:0] out_s [4];

  // Odd columns/rows never fall in the ignored edge of an odd-sized frame,
  // so the strobes need no extra range gating.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pair_we_s   = 1'b0;
    lb_we_s     = 1'b0;
    out_we_s    = 1'b0;
    last_out_d  = 1'b0;
    idx_s       = IDX_W'(col_q >> 1);
    if (valid_in) begin
      if (col_q == CW'(IMG_Width - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_Height - 1)) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
      pair_we_s  = ~col_q[0];
      lb_we_s    = col_q[0] & ~row_q[0];
      out_we_s   = col_q[0] & row_q[0];
      last_out_d = out_we_s && (col_q == CW'(2 * PW - 1)) && (row_q == RW'(2 * PH - 1));
    end else begin
      col_d = col_q;
    end
    valid_out_d = out_we_s;
  end

  // Position counters and output strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
    end
  end

  assign in_s[0] = In_0;
  assign in_s[1] = In_1;
  assign in_s[2] = In_2;
  assign in_s[3] = In_3;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    maxpool2x2_lane #(
      .DW     (Datawidth),
      .PW     (PW),
      .IDX_W  (IDX_W),
      .SIGNED (Signed)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .pair_we (pair_we_s),
      .lb_we   (lb_we_s),
      .out_we  (out_we_s),
      .idx     (idx_s),
      .din     (in_s[k]),
      .dout    (out_s[k])
    );
  end

  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;
  assign Out_0     = out_s[0];
  assign Out_1     = out_s[1];
  assign Out_2     = out_s[2];
  assign Out_3     = out_s[3];

endmodule

// File: tb/tb_layer2_maxpool2x2_stride2_depth4.sv
// Scoreboard bench: three pool instances (4x4 signed, 4x4 unsigned, 5x5 signed)
// fed from a frame-level reference model.
module tb_layer2_maxpool2x2_stride2_depth4;

  typedef struct packed {
    logic [3:0][31:0] d;
    logic             last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        va = 1'b0, vb = 1'b0, vc = 1'b0;
  logic [31:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic        a_vo, a_lo, b_vo, b_lo, c_vo, c_lo;
  logic [31:0] a_o0, a_o1, a_o2, a_o3, b_o0, b_o1, b_o2, b_o3, c_o0, c_o1, c_o2, c_o3;

  exp_t        qa[$], qb[$], qc[$];
  logic [31:0] fm [4][25];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          done     = 1'b0;
  bit   [2:0]  prev_v   = 3'b000;

  always #5 clk = ~clk;

  layer2_maxpool2x2_stride2_depth4 #(.IMG_Width(4), .IMG_Height(4), .Datawidth(32), .Signed(1)) dut_a (
    .clk(clk), .rst(rst), .valid_in(va), .In_0(in0), .In_1(in1), .In_2(in2), .In_3(in3),
    .valid_out(a_vo), .Out_0(a_o0), .Out_1(a_o1), .Out_2(a_o2), .Out_3(a_o3), .last_out(a_lo));
  layer2_maxpool2x2_stride2_depth4 #(.IMG_Width(4), .IMG_Height(4), .Datawidth(32), .Signed(0)) dut_b (
    .clk(clk), .rst(rst), .valid_in(vb), .In_0(in0), .In_1(in1), .In_2(in2), .In_3(in3),
    .valid_out(b_vo), .Out_0(b_o0), .Out_1(b_o1), .Out_2(b_o2), .Out_3(b_o3), .last_out(b_lo));
  layer2_maxpool2x2_stride2_depth4 #(.IMG_Width(5), .IMG_Height(5), .Datawidth(32), .Signed(1)) dut_c (
    .clk(clk), .rst(rst), .valid_in(vc), .In_0(in0), .In_1(in1), .In_2(in2), .In_3(in3),
    .valid_out(c_vo), .Out_0(c_o0), .Out_1(c_o1), .Out_2(c_o2), .Out_3(c_o3), .last_out(c_lo));

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    if (sgn) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  // mode 0: i+100k, mode 1: random, mode 2: i+100k with block (0,0) = {-3,5,-7,-2}
  task automatic build_frame(input int w, input int h, input int mode);
    for (int i = 0; i < w * h; i++) begin
      for (int k = 0; k < 4; k++) begin
        fm[k][i] = (mode == 1) ? $urandom : 32'(i + 100 * k);
      end
    end
    if (mode == 2) begin
      for (int k = 0; k < 4; k++) begin
        fm[k][0]     = -32'sd3;
        fm[k][1]     = 32'sd5;
        fm[k][w]     = -32'sd7;
        fm[k][w + 1] = -32'sd2;
      end
    end
  endtask

  // Each pooled pixel is emitted once its bottom-right source beat has been sent.
  task automatic expect_frame(input int d, input int w, input int h, input int nbeats, input bit sgn);
    exp_t e;
    int   pw, ph, b;
    pw = w / 2;
    ph = h / 2;
    for (int py = 0; py < ph; py++) begin
      for (int px = 0; px < pw; px++) begin
        b = (2 * py) * w + 2 * px;
        if (b + w + 1 < nbeats) begin
          for (int k = 0; k < 4; k++) begin
            e.d[k] = ref_max(ref_max(fm[k][b], fm[k][b + 1], sgn),
                             ref_max(fm[k][b + w], fm[k][b + w + 1], sgn), sgn);
          end
          e.last = (px == pw - 1) && (py == ph - 1);
          if (d == 0) qa.push_back(e);
          else if (d == 1) qb.push_back(e);
          else qc.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      va = 1'b0; vb = 1'b0; vc = 1'b0;
    end
  endtask

  // gap 0: none, 1: one idle cycle between beats, 2: random 0..2 idle cycles
  task automatic drive_frame(input bit [2:0] mask, input int nbeats, input int gap);
    for (int i = 0; i < nbeats; i++) begin
      if (gap == 1 && i > 0) idle(1);
      if (gap == 2) idle($urandom_range(0, 2));
      @(negedge clk);
      #1;
      in0 = fm[0][i]; in1 = fm[1][i]; in2 = fm[2][i]; in3 = fm[3][i];
      va = mask[0]; vb = mask[1]; vc = mask[2];
    end
  endtask

  task automatic frame(input bit [2:0] mask, input int w, input int mode, input int nbeats, input int gap);
    build_frame(w, w, mode);
    if (mask[0]) expect_frame(0, w, w, nbeats, 1'b1);
    if (mask[1]) expect_frame(1, w, w, nbeats, 1'b0);
    if (mask[2]) expect_frame(2, w, w, nbeats, 1'b1);
    drive_frame(mask, nbeats, gap);
  endtask

  task automatic check_dut(input int d, input logic v, input logic lst, input logic [3:0][31:0] o);
    exp_t e;
    int   sz;
    if (v) begin
      n_checks++;
      if (prev_v[d]) begin
        n_fail++;
        $display("FAIL spacing dut%0d: valid_out high on consecutive cycles, required a gap", d);
      end
      sz = (d == 0) ? qa.size() : (d == 1) ? qb.size() : qc.size();
      n_checks++;
      if (sz == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse dut%0d: got %h %h %h %h, expected no output", d, o[0], o[1], o[2], o[3]);
      end else begin
        if (d == 0) e = qa.pop_front();
        else if (d == 1) e = qb.pop_front();
        else e = qc.pop_front();
        for (int k = 0; k < 4; k++) begin
          n_checks++;
          if (o[k] !== e.d[k]) begin
            n_fail++;
            $display("FAIL out dut%0d ch%0d: got %h expected %h", d, k, o[k], e.d[k]);
          end
        end
        n_checks++;
        if (lst !== e.last) begin
          n_fail++;
          $display("FAIL last_out dut%0d: got %b expected %b", d, lst, e.last);
        end
      end
    end
    prev_v[d] = v;
  endtask

  task automatic check_rst(input int d, input logic v, input logic lst, input logic [3:0][31:0] o);
    n_checks++;
    if (v !== 1'b0 || lst !== 1'b0 || o !== '0) begin
      n_fail++;
      $display("FAIL reset dut%0d: got valid=%b last=%b out=%h, expected all zero", d, v, lst, o);
    end
    prev_v[d] = 1'b0;
  endtask

  task automatic check_drained(input int d, input int sz);
    n_checks++;
    if (sz != 0) begin
      n_fail++;
      $display("FAIL missing_pulses dut%0d: %0d expected outputs never appeared, expected 0", d, sz);
    end
  endtask

  // Monitor: the only process that updates the check/failure counters.
  always @(negedge clk) begin
    if (done) begin
      check_drained(0, qa.size());
      check_drained(1, qb.size());
      check_drained(2, qc.size());
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end else if (!rst) begin
      check_rst(0, a_vo, a_lo, {a_o3, a_o2, a_o1, a_o0});
      check_rst(1, b_vo, b_lo, {b_o3, b_o2, b_o1, b_o0});
      check_rst(2, c_vo, c_lo, {c_o3, c_o2, c_o1, c_o0});
    end else begin
      check_dut(0, a_vo, a_lo, {a_o3, a_o2, a_o1, a_o0});
      check_dut(1, b_vo, b_lo, {b_o3, b_o2, b_o1, b_o0});
      check_dut(2, c_vo, c_lo, {c_o3, c_o2, c_o1, c_o0});
    end
  end

  initial begin
    idle(2);
    rst = 1'b1;
    idle(2);
    frame(3'b011, 4, 0, 16, 0);          // basic ramp, both compare modes
    idle(3);
    frame(3'b011, 4, 0, 16, 1);          // same data with gaps
    idle(3);
    frame(3'b011, 4, 2, 16, 0);          // signed vs unsigned block
    idle(3);
    frame(3'b100, 5, 0, 25, 0);          // odd frame size, two frames
    frame(3'b100, 5, 0, 25, 0);
    idle(3);
    frame(3'b001, 4, 0, 6, 0);           // partial frame then reset
    @(negedge clk);
    #1;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    frame(3'b001, 4, 0, 16, 0);
    idle(2);
    for (int f = 0; f < 3; f++) frame(3'b001, 4, 0, 16, 0);  // back-to-back frames
    idle(3);
    for (int f = 0; f < 4; f++) frame(3'b011, 4, 1, 16, 2);  // random data and gaps
    for (int f = 0; f < 3; f++) frame(3'b100, 5, 1, 25, 2);
    idle(5);
    done = 1'b1;
  end

endmodule
